// File: rtl/demod_pkg.sv
// Shared types, default widths and the saturating add used by the
// iq_window_integrator accumulators.
package demod_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_INTEG,
        S_DRAIN,
        S_CLASS,
        S_DONE
    } state_t;

    localparam int DEF_N_CH  = 2;
    localparam int DEF_LANES = 5;
    localparam int DEF_DW    = 16;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_CW    = 16;

    // Wide enough to hold any accumulator plus any lane sum without wrap.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] sum;
    } sat_res_t;

    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             acc_w
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_res_t              r;
        s     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi    = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
        lo    = -(65'sd1 <<< (acc_w - 1));
        r.sat = 1'b0;
        r.sum = s[SAT_W-1:0];
        if (s > hi) begin
            r.sat = 1'b1;
            r.sum = hi[SAT_W-1:0];
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.sum = lo[SAT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_lane_adder.sv
// Registered sum of LANES signed samples of one stream, with a valid flag
// that follows the enable one clock later.
module iq_lane_adder
    import demod_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DW    = DEF_DW,
    parameter int SUM_W = DW + $clog2(LANES)
) (
    input  logic                    clk100,
    input  logic                    reset,
    input  logic                    en,
    input  logic [LANES*DW-1:0]     samples,
    output logic                    valid,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [SUM_W-1:0] comb_sum;

    always_comb begin
        comb_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            comb_sum = comb_sum + SUM_W'($signed(samples[l*DW +: DW]));
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            valid <= 1'b0;
            sum   <= '0;
        end else begin
            valid <= en;
            if (en) begin
                sum <= comb_sum;
            end
        end
    end

endmodule

// File: rtl/iq_window_integrator.sv
// Triggered, delayed, windowed I/Q integration per channel with saturating
// accumulators and a linear discriminator on the integrated point.
module iq_window_integrator
    import demod_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int LANES = DEF_LANES,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int CW    = DEF_CW
) (
    input  logic                          clk100,
    input  logic                          reset,
    input  logic                          trigger,
    input  logic                          data_valid,
    input  logic [N_CH*LANES*DW-1:0]      i_data,
    input  logic [N_CH*LANES*DW-1:0]      q_data,
    input  logic [CNT_W-1:0]              cfg_delay,
    input  logic [CNT_W-1:0]              cfg_window,
    input  logic [N_CH*CW-1:0]            cfg_i_perp,
    input  logic [N_CH*CW-1:0]            cfg_q_perp,
    input  logic [N_CH*(ACC_W+CW+1)-1:0]  cfg_thresh,
    output logic                          busy,
    output logic                          overrun,
    output logic                          res_valid,
    output logic [N_CH*ACC_W-1:0]         res_i,
    output logic [N_CH*ACC_W-1:0]         res_q,
    output logic [N_CH-1:0]               res_state,
    output logic [N_CH-1:0]               res_sat
);

    localparam int SUM_W = DW + $clog2(LANES);
    localparam int PW    = ACC_W + CW + 1;
    localparam int LW    = LANES * DW;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] delay_r;
    logic [CNT_W-1:0] window_r;
    logic             start;
    logic             s1_en;
    logic             proj_load;
    logic             res_load;

    assign start     = (state == S_IDLE) && trigger;
    assign s1_en     = (state == S_INTEG) && data_valid;
    assign proj_load = (state == S_DRAIN) && (nxt == S_CLASS);
    assign res_load  = (state == S_CLASS);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    nxt = (cfg_delay != '0) ? S_DELAY : S_INTEG;
                end
            end
            S_DELAY: begin
                if (data_valid && cnt == delay_r - CNT_W'(1)) begin
                    nxt = S_INTEG;
                end
            end
            S_INTEG: begin
                if (data_valid && cnt == window_r - CNT_W'(1)) begin
                    nxt = S_DRAIN;
                end
            end
            // Two cycles: last lane sum lands in stage 1, then in the accumulator.
            S_DRAIN: begin
                if (cnt == CNT_W'(1)) begin
                    nxt = S_CLASS;
                end
            end
            S_CLASS: nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            delay_r  <= '0;
            window_r <= '0;
            overrun  <= 1'b0;
        end else begin
            state   <= nxt;
            overrun <= trigger && (state != S_IDLE);
            if (state != nxt) begin
                cnt <= '0;
            end else if (state == S_DRAIN ||
                         ((state == S_DELAY || state == S_INTEG) && data_valid)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (start) begin
                delay_r  <= cfg_delay;
                window_r <= (cfg_window == '0) ? CNT_W'(1) : cfg_window;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic                    i_v;
        logic                    q_v;
        logic signed [SUM_W-1:0] i_sum;
        logic signed [SUM_W-1:0] q_sum;
        logic signed [ACC_W-1:0] acc_i;
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] out_i;
        logic signed [ACC_W-1:0] out_q;
        logic                    sat;
        logic                    out_sat;
        logic                    out_state;
        logic signed [CW-1:0]    i_perp;
        logic signed [CW-1:0]    q_perp;
        logic signed [PW-1:0]    thresh;
        logic signed [PW-1:0]    ext_i;
        logic signed [PW-1:0]    ext_q;
        logic signed [PW-1:0]    ext_ip;
        logic signed [PW-1:0]    ext_qp;
        logic signed [PW-1:0]    proj_next;
        logic signed [PW-1:0]    proj;
        sat_res_t                add_i;
        sat_res_t                add_q;
        logic                    unused_hi;

        iq_lane_adder #(
            .LANES (LANES),
            .DW    (DW),
            .SUM_W (SUM_W)
        ) u_i (
            .clk100  (clk100),
            .reset   (reset),
            .en      (s1_en),
            .samples (i_data[c*LW +: LW]),
            .valid   (i_v),
            .sum     (i_sum)
        );

        iq_lane_adder #(
            .LANES (LANES),
            .DW    (DW),
            .SUM_W (SUM_W)
        ) u_q (
            .clk100  (clk100),
            .reset   (reset),
            .en      (s1_en),
            .samples (q_data[c*LW +: LW]),
            .valid   (q_v),
            .sum     (q_sum)
        );

        always_comb begin
            add_i = sat_add(SAT_W'(acc_i), SAT_W'(i_sum), ACC_W);
            add_q = sat_add(SAT_W'(acc_q), SAT_W'(q_sum), ACC_W);
        end

        // Clamped results always fit ACC_W, so the upper bits carry nothing.
        assign unused_hi = ^{add_i.sum[SAT_W-1:ACC_W], add_q.sum[SAT_W-1:ACC_W]};

        assign ext_i     = {{(PW-ACC_W){acc_i[ACC_W-1]}}, acc_i};
        assign ext_q     = {{(PW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        assign ext_ip    = {{(PW-CW){i_perp[CW-1]}}, i_perp};
        assign ext_qp    = {{(PW-CW){q_perp[CW-1]}}, q_perp};
        assign proj_next = ext_i * ext_ip + ext_q * ext_qp;

        always_ff @(posedge clk100) begin
            if (reset) begin
                i_perp    <= '0;
                q_perp    <= '0;
                thresh    <= '0;
                acc_i     <= '0;
                acc_q     <= '0;
                sat       <= 1'b0;
                proj      <= '0;
                out_i     <= '0;
                out_q     <= '0;
                out_sat   <= 1'b0;
                out_state <= 1'b0;
            end else begin
                if (start) begin
                    i_perp <= cfg_i_perp[c*CW +: CW];
                    q_perp <= cfg_q_perp[c*CW +: CW];
                    thresh <= cfg_thresh[c*PW +: PW];
                    acc_i  <= '0;
                    acc_q  <= '0;
                    sat    <= 1'b0;
                end else begin
                    if (i_v) begin
                        acc_i <= add_i.sum[ACC_W-1:0];
                    end
                    if (q_v) begin
                        acc_q <= add_q.sum[ACC_W-1:0];
                    end
                    if ((i_v && add_i.sat) || (q_v && add_q.sat)) begin
                        sat <= 1'b1;
                    end
                end
                if (proj_load) begin
                    proj <= proj_next;
                end
                if (res_load) begin
                    out_i     <= acc_i;
                    out_q     <= acc_q;
                    out_sat   <= sat;
                    out_state <= (proj >= thresh);
                end
            end
        end

        assign res_i[c*ACC_W +: ACC_W] = out_i;
        assign res_q[c*ACC_W +: ACC_W] = out_q;
        assign res_state[c]            = out_state;
        assign res_sat[c]              = out_sat;
    end

endmodule

// File: tb/tb_iq_window_integrator.sv
// Randomised bench for iq_window_integrator against a beat-list model of
// delay skipping, saturating window sums and line classification.
module tb_iq_window_integrator;

    localparam int N_CH  = 2;
    localparam int LANES = 5;
    localparam int DW    = 16;
    localparam int ACC_W = 20;
    localparam int CNT_W = 16;
    localparam int CW    = 16;
    localparam int PW    = ACC_W + CW + 1;
    localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));

    logic                        clk100 = 1'b0;
    logic                        reset;
    logic                        trigger;
    logic                        data_valid;
    logic [N_CH*LANES*DW-1:0]    i_data;
    logic [N_CH*LANES*DW-1:0]    q_data;
    logic [CNT_W-1:0]            cfg_delay;
    logic [CNT_W-1:0]            cfg_window;
    logic [N_CH*CW-1:0]          cfg_i_perp;
    logic [N_CH*CW-1:0]          cfg_q_perp;
    logic [N_CH*PW-1:0]          cfg_thresh;
    logic                        busy;
    logic                        overrun;
    logic                        res_valid;
    logic [N_CH*ACC_W-1:0]       res_i;
    logic [N_CH*ACC_W-1:0]       res_q;
    logic [N_CH-1:0]             res_state;
    logic [N_CH-1:0]             res_sat;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     ip [N_CH];
    int     qp [N_CH];
    longint th [N_CH];
    int     ci [N_CH];
    int     cq [N_CH];
    longint ai [N_CH];
    longint aq [N_CH];
    bit     sat[N_CH];
    int     beats;

    iq_window_integrator #(
        .N_CH  (N_CH),
        .LANES (LANES),
        .DW    (DW),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W),
        .CW    (CW)
    ) dut (
        .clk100     (clk100),
        .reset      (reset),
        .trigger    (trigger),
        .data_valid (data_valid),
        .i_data     (i_data),
        .q_data     (q_data),
        .cfg_delay  (cfg_delay),
        .cfg_window (cfg_window),
        .cfg_i_perp (cfg_i_perp),
        .cfg_q_perp (cfg_q_perp),
        .cfg_thresh (cfg_thresh),
        .busy       (busy),
        .overrun    (overrun),
        .res_valid  (res_valid),
        .res_i      (res_i),
        .res_q      (res_q),
        .res_state  (res_state),
        .res_sat    (res_sat)
    );

    always #5 clk100 = ~clk100;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint rd_i(input int c);
        return longint'($signed(res_i[c*ACC_W +: ACC_W]));
    endfunction

    function automatic longint rd_q(input int c);
        return longint'($signed(res_q[c*ACC_W +: ACC_W]));
    endfunction

    function automatic longint clamp(input longint v, output bit hit);
        hit = 1'b0;
        if (v > AMAX) begin
            hit = 1'b1;
            return AMAX;
        end
        if (v < AMIN) begin
            hit = 1'b1;
            return AMIN;
        end
        return v;
    endfunction

    function automatic int lane_val(input int dmode, input int c, input bit q, input int ord);
        case (dmode)
            0:       return q ? cq[c] : ci[c];
            1:       return ord;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic drive_beat(input int dmode, input bit dv, input bit integ);
        int     vi;
        int     vq;
        longint si;
        longint sq;
        bit     h;
        data_valid = dv;
        for (int c = 0; c < N_CH; c++) begin
            si = 0;
            sq = 0;
            for (int l = 0; l < LANES; l++) begin
                vi = lane_val(dmode, c, 1'b0, beats + 1);
                vq = lane_val(dmode, c, 1'b1, beats + 1);
                i_data[(c*LANES+l)*DW +: DW] = DW'(vi);
                q_data[(c*LANES+l)*DW +: DW] = DW'(vq);
                si += vi;
                sq += vq;
            end
            if (integ) begin
                ai[c] = clamp(ai[c] + si, h);
                if (h) sat[c] = 1'b1;
                aq[c] = clamp(aq[c] + sq, h);
                if (h) sat[c] = 1'b1;
            end
        end
    endtask

    task automatic set_cfg(input int dly, input int win);
        cfg_delay  = CNT_W'(dly);
        cfg_window = CNT_W'(win);
        for (int c = 0; c < N_CH; c++) begin
            cfg_i_perp[c*CW +: CW] = CW'(ip[c]);
            cfg_q_perp[c*CW +: CW] = CW'(qp[c]);
            cfg_thresh[c*PW +: PW] = PW'(th[c]);
        end
    endtask

    task automatic scramble_cfg();
        cfg_delay  = CNT_W'($urandom);
        cfg_window = CNT_W'($urandom);
        cfg_i_perp = $urandom;
        cfg_q_perp = $urandom;
        for (int c = 0; c < N_CH; c++) begin
            cfg_thresh[c*PW +: PW] = PW'({$urandom, $urandom});
        end
    endtask

    // One complete shot; enters and leaves just after a falling edge.
    task automatic run_shot(input string name, input int dly, input int win,
                            input int vmode, input int dmode,
                            input bit ovr_i, input bit ovr_d);
        int     need;
        int     cyc;
        bit     dv;
        bit     busy_low;
        bit     early;
        bit     inj_done;
        bit     inj_pend;
        longint proj;
        longint held;
        need = dly + ((win == 0) ? 1 : win);
        for (int c = 0; c < N_CH; c++) begin
            ai[c]  = 0;
            aq[c]  = 0;
            sat[c] = 1'b0;
        end
        beats = 0;
        set_cfg(dly, win);
        trigger = 1'b1;
        drive_beat(dmode, 1'b1, 1'b0);
        @(negedge clk100);
        trigger = 1'b0;
        scramble_cfg();
        busy_low = 1'b0;
        inj_done = 1'b0;
        inj_pend = 1'b0;
        cyc      = 0;
        while (beats < need && cyc < 4000) begin
            if (!busy) busy_low = 1'b1;
            if (inj_pend) begin
                check({name, ".ovr_integ"}, longint'(overrun), 1);
                inj_pend = 1'b0;
            end
            trigger = 1'b0;
            if (ovr_i && !inj_done && beats >= dly) begin
                trigger  = 1'b1;
                inj_done = 1'b1;
                inj_pend = 1'b1;
            end
            case (vmode)
                0:       dv = 1'b1;
                1:       dv = (cyc % 2 == 0);
                default: dv = 1'($urandom_range(0, 1));
            endcase
            drive_beat(dmode, dv, dv && (beats >= dly));
            if (dv) beats++;
            @(negedge clk100);
            cyc++;
        end
        trigger = 1'b0;
        if (beats < need) begin
            check({name, ".timeout"}, 1, 0);
            return;
        end
        if (inj_pend) begin
            check({name, ".ovr_integ"}, longint'(overrun), 1);
        end
        early = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            if (res_valid) early = 1'b1;
            if (!busy) busy_low = 1'b1;
            drive_beat(2, 1'($urandom_range(0, 1)), 1'b0);
            @(negedge clk100);
        end
        check({name, ".early_valid"}, longint'(early), 0);
        check({name, ".latency"}, longint'(res_valid), 1);
        if (!busy) busy_low = 1'b1;
        check({name, ".busy"}, longint'(busy_low), 0);
        for (int c = 0; c < N_CH; c++) begin
            proj = ai[c] * ip[c] + aq[c] * qp[c];
            check($sformatf("%s.i%0d", name, c), rd_i(c), ai[c]);
            check($sformatf("%s.q%0d", name, c), rd_q(c), aq[c]);
            check($sformatf("%s.state%0d", name, c), longint'(res_state[c]),
                  longint'(proj >= th[c]));
            check($sformatf("%s.sat%0d", name, c), longint'(res_sat[c]), longint'(sat[c]));
        end
        held    = rd_i(0);
        trigger = ovr_d;
        @(negedge clk100);
        trigger = 1'b0;
        check({name, ".one_pulse"}, longint'(res_valid), 0);
        check({name, ".idle"}, longint'(busy), 0);
        check({name, ".ovr_done"}, longint'(overrun), longint'(ovr_d));
        check({name, ".hold"}, rd_i(0), held);
        drive_beat(2, 1'b0, 1'b0);
        @(negedge clk100);
        check({name, ".no_restart"}, longint'(busy), 0);
    endtask

    task automatic reset_mid();
        bit seen;
        for (int c = 0; c < N_CH; c++) begin
            ci[c] = 400;
            cq[c] = -400;
        end
        beats = 0;
        set_cfg(0, 8);
        trigger = 1'b1;
        drive_beat(0, 1'b0, 1'b0);
        @(negedge clk100);
        trigger = 1'b0;
        repeat (3) begin
            drive_beat(0, 1'b1, 1'b0);
            @(negedge clk100);
        end
        reset = 1'b1;
        @(negedge clk100);
        reset = 1'b0;
        check("rst.busy", longint'(busy), 0);
        check("rst.valid", longint'(res_valid), 0);
        check("rst.overrun", longint'(overrun), 0);
        check("rst.res_i", longint'(res_i), 0);
        check("rst.res_q", longint'(res_q), 0);
        check("rst.state", longint'(res_state), 0);
        check("rst.sat", longint'(res_sat), 0);
        seen = 1'b0;
        repeat (12) begin
            drive_beat(0, 1'b1, 1'b0);
            @(negedge clk100);
            if (res_valid || busy) seen = 1'b1;
        end
        check("rst.aborted", longint'(seen), 0);
    endtask

    initial begin
        reset      = 1'b1;
        trigger    = 1'b0;
        data_valid = 1'b0;
        i_data     = '0;
        q_data     = '0;
        cfg_delay  = '0;
        cfg_window = '0;
        cfg_i_perp = '0;
        cfg_q_perp = '0;
        cfg_thresh = '0;
        beats      = 0;
        repeat (3) @(negedge clk100);
        check("init.busy", longint'(busy), 0);
        check("init.valid", longint'(res_valid), 0);
        check("init.overrun", longint'(overrun), 0);
        check("init.res_i", longint'(res_i), 0);
        check("init.state", longint'(res_state), 0);
        reset = 1'b0;
        @(negedge clk100);

        for (int c = 0; c < N_CH; c++) begin
            ip[c] = 1;
            qp[c] = 0;
            th[c] = 0;
        end
        ci[0] = 100;
        cq[0] = -50;
        ci[1] = 7;
        cq[1] = -3;
        run_shot("basic", 0, 4, 0, 0, 1'b0, 1'b0);
        check("basic.i0_abs", rd_i(0), 2000);
        check("basic.q0_abs", rd_q(0), -1000);

        run_shot("gap", 3, 2, 1, 1, 1'b0, 1'b0);
        check("gap.i0_abs", rd_i(0), 45);

        for (int c = 0; c < N_CH; c++) begin
            ci[c] = 32767;
            cq[c] = -32768;
        end
        run_shot("sat", 0, 8, 0, 0, 1'b0, 1'b0);
        check("sat.i0_abs", rd_i(0), 524287);
        check("sat.q0_abs", rd_q(0), -524288);
        check("sat.flags", longint'(res_sat), 3);
        for (int c = 0; c < N_CH; c++) begin
            ci[c] = 0;
            cq[c] = 0;
        end
        run_shot("unsat", 0, 8, 0, 0, 1'b0, 1'b0);
        check("unsat.flags", longint'(res_sat), 0);
        check("unsat.i0_abs", rd_i(0), 0);

        run_shot("win0", 2, 0, 2, 2, 1'b0, 1'b0);

        for (int c = 0; c < N_CH; c++) begin
            ip[c] = 1;
            qp[c] = -1;
            th[c] = 0;
            ci[c] = 2;
            cq[c] = 1;
        end
        run_shot("cls_hi", 0, 1, 0, 0, 1'b0, 1'b0);
        check("cls_hi.abs", longint'(res_state), 3);
        for (int c = 0; c < N_CH; c++) begin
            ci[c] = 1;
            cq[c] = 2;
        end
        run_shot("cls_lo", 0, 1, 0, 0, 1'b0, 1'b0);
        check("cls_lo.abs", longint'(res_state), 0);
        for (int c = 0; c < N_CH; c++) begin
            ci[c] = 2;
            cq[c] = 2;
        end
        run_shot("cls_eq", 0, 1, 0, 0, 1'b0, 1'b0);
        check("cls_eq.abs", longint'(res_state), 3);

        run_shot("ovr", 2, 6, 2, 2, 1'b1, 1'b1);

        reset_mid();
        for (int c = 0; c < N_CH; c++) begin
            ci[c] = 300;
            cq[c] = -7;
        end
        run_shot("post_rst", 1, 5, 0, 0, 1'b0, 1'b0);
        check("post_rst.i0_abs", rd_i(0), 7500);

        for (int k = 0; k < 24; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                ip[c] = int'($urandom_range(0, 65535)) - 32768;
                qp[c] = int'($urandom_range(0, 65535)) - 32768;
                th[c] = longint'(int'($urandom)) <<< $urandom_range(0, 4);
            end
            run_shot($sformatf("rnd%0d", k), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 12)), 2, 2,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
